// File: rtl/load_use_stall_unit.sv
// rtl/load_use_stall_unit.sv - load-use RAW hazard stall unit
//
// Purpose:
//   Sits between the IF/ID and ID/RF pipeline registers. When the instruction
//   in IF/ID consumes the destination of a valid load that is currently in
//   ID/RF, the unit holds PC and IF/ID for LOAD_LAT cycles and injects
//   bubbles into ID/RF. A flush aborts a stall immediately. Stalled cycles
//   are counted in a saturating statistics counter.
//
// Ports:
//   clock           in   rising-edge clock
//   reset           in   asynchronous active-low reset
//   IF_ID_src1      in   source 1 register index of the IF/ID instruction
//   IF_ID_src2      in   source 2 register index of the IF/ID instruction
//   IF_ID_opcode    in   opcode of the IF/ID instruction
//   ID_RF_dest      in   destination register index of the ID/RF instruction
//   ID_RF_opcode    in   opcode of the ID/RF instruction
//   Valid_out_ID_RF in   ID/RF entry valid
//   flush           in   branch/redirect flush, aborts any stall
//   mux_enable      out  0 = select bubble into ID/RF
//   valid_in        out  0 = write valid=0 into ID/RF
//   enable          out  0 = hold PC and IF/ID
//   stall_active    out  1 while stalling
//   hazard_src      out  {src2 hit, src1 hit}, only in the detect cycle
//   stall_count     out  saturating count of stalled cycles

module load_use_stall_unit #(
  parameter int unsigned            REG_W       = 3,
  parameter int unsigned            OP_W        = 4,
  parameter logic [OP_W-1:0]        OPC_LW      = 4'b0100,
  parameter logic [2**OP_W-1:0]     SRC1_MASK   = 16'h0107,
  parameter logic [2**OP_W-1:0]     SRC2_MASK   = 16'h0107,
  parameter int unsigned            LOAD_LAT    = 1,
  parameter int unsigned            ZERO_REG_EN = 0,
  parameter int unsigned            CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] IF_ID_src1,
  input  logic [REG_W-1:0] IF_ID_src2,
  input  logic [OP_W-1:0]  IF_ID_opcode,
  input  logic [REG_W-1:0] ID_RF_dest,
  input  logic [OP_W-1:0]  ID_RF_opcode,
  input  logic             Valid_out_ID_RF,
  input  logic             flush,
  output logic             mux_enable,
  output logic             valid_in,
  output logic             enable,
  output logic             stall_active,
  output logic [1:0]       hazard_src,
  output logic [CNT_W-1:0] stall_count
);

  if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_load_lat
    $error("load_use_stall_unit: LOAD_LAT must be within 1..7");
  end

  // Cycles remaining after the detect cycle; only meaningful when LOAD_LAT > 1.
  localparam logic [2:0] LAT_M1     = 3'(LOAD_LAT - 1);
  localparam bit         MULTI_LAT  = (LOAD_LAT > 1);
  localparam bit         ZERO_SUPPR = (ZERO_REG_EN != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;

  logic dest_ok;
  logic hit1;
  logic hit2;
  logic load_in_rf;
  logic hazard;
  logic stall;

  // Hazard detection. Reset gates the hazard so the outputs go inactive the
  // instant reset is asserted, without waiting for the state register.
  always_comb begin
    dest_ok    = ZERO_SUPPR ? (ID_RF_dest != '0) : 1'b1;
    hit1       = (IF_ID_src1 == ID_RF_dest) && SRC1_MASK[IF_ID_opcode] && dest_ok;
    hit2       = (IF_ID_src2 == ID_RF_dest) && SRC2_MASK[IF_ID_opcode] && dest_ok;
    load_in_rf = (ID_RF_opcode == OPC_LW) && Valid_out_ID_RF;
    hazard     = reset && load_in_rf && (hit1 || hit2) && !flush && (state == IDLE);
  end

  // Next-state logic. A single-cycle latency never leaves IDLE: the bubble
  // written into ID/RF during the detect cycle removes the load, so the
  // following cycle cannot re-hit on the same instruction pair.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = hazard;
        if (hazard && MULTI_LAT) begin
          state_nxt = STALL;
          cnt_nxt   = LAT_M1;
        end
      end
      STALL: begin
        stall = !flush;
        if (flush || (cnt == 3'd1)) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
    if (!reset) begin
      stall = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Statistics counter saturates at all-ones so long runs never wrap to zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  always_comb begin
    mux_enable   = !stall;
    valid_in     = !stall;
    enable       = !stall;
    stall_active = stall;
    hazard_src   = hazard ? {hit2, hit1} : 2'b00;
  end

endmodule

// File: tb/tb_load_use_stall_unit.sv
// tb/tb_load_use_stall_unit.sv - scoreboard bench for load_use_stall_unit
//
// Five instances share one stimulus bus:
//   0: LOAD_LAT=1   1: LOAD_LAT=3   2: LOAD_LAT=4
//   3: LOAD_LAT=1, ZERO_REG_EN=1    4: LOAD_LAT=1, CNT_W=4

module tb_load_use_stall_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] if_src1 = '0;
  logic [2:0] if_src2 = '0;
  logic [3:0] if_op = '0;
  logic [2:0] id_dest = '0;
  logic [3:0] id_op = '0;
  logic       id_valid = 1'b0;
  logic       flush = 1'b0;

  always #5 clock = ~clock;

  logic [3:0]  o_vec [5];
  logic [1:0]  o_hs  [5];
  logic [15:0] o_cnt [5];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int LL = (g == 1) ? 3 : (g == 2) ? 4 : 1;
    localparam int ZE = (g == 3) ? 1 : 0;
    localparam int CW = (g == 4) ? 4 : 16;
    logic          me;
    logic          vi;
    logic          en;
    logic          sa;
    logic [1:0]    hs;
    logic [CW-1:0] sc;

    load_use_stall_unit #(
      .LOAD_LAT    (LL),
      .ZERO_REG_EN (ZE),
      .CNT_W       (CW)
    ) u_dut (
      .clock           (clock),
      .reset           (reset),
      .IF_ID_src1      (if_src1),
      .IF_ID_src2      (if_src2),
      .IF_ID_opcode    (if_op),
      .ID_RF_dest      (id_dest),
      .ID_RF_opcode    (id_op),
      .Valid_out_ID_RF (id_valid),
      .flush           (flush),
      .mux_enable      (me),
      .valid_in        (vi),
      .enable          (en),
      .stall_active    (sa),
      .hazard_src      (hs),
      .stall_count     (sc)
    );

    assign o_vec[g] = {me, vi, en, sa};
    assign o_hs[g]  = hs;
    assign o_cnt[g] = 16'(sc);
  end

  typedef struct {
    int          dut;
    logic        stall;
    logic [1:0]  hs;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: every expectation pushed during a cycle is checked at that
  // cycle's falling edge.
  always @(negedge clock) begin
    while (q.size() > 0) begin
      exp_t       e;
      logic [3:0] want_vec;
      e        = q.pop_front();
      want_vec = {~e.stall, ~e.stall, ~e.stall, e.stall};
      n_tests++;
      if (o_vec[e.dut] !== want_vec) begin
        n_fail++;
        $display("FAIL %s dut%0d outputs{mux,vin,en,act}: got %b want %b",
                 e.name, e.dut, o_vec[e.dut], want_vec);
      end
      n_tests++;
      if (o_hs[e.dut] !== e.hs) begin
        n_fail++;
        $display("FAIL %s dut%0d hazard_src: got %b want %b",
                 e.name, e.dut, o_hs[e.dut], e.hs);
      end
      n_tests++;
      if (o_cnt[e.dut] !== e.cnt) begin
        n_fail++;
        $display("FAIL %s dut%0d stall_count: got %0d want %0d",
                 e.name, e.dut, o_cnt[e.dut], e.cnt);
      end
    end
  end

  task automatic drive(input logic [2:0] s1, input logic [2:0] s2, input logic [3:0] op,
                       input logic [2:0] d, input logic [3:0] dop, input logic v,
                       input logic fl);
    @(posedge clock);
    #1;
    if_src1  = s1;
    if_src2  = s2;
    if_op    = op;
    id_dest  = d;
    id_op    = dop;
    id_valid = v;
    flush    = fl;
  endtask

  task automatic push_exp(input int dut, input logic st, input logic [1:0] hs,
                          input logic [15:0] c, input string nm);
    exp_t e;
    e.dut   = dut;
    e.stall = st;
    e.hs    = hs;
    e.cnt   = c;
    e.name  = nm;
    q.push_back(e);
  endtask

  // LW r3 in ID/RF, ADD reading r3 via src1 / via src2.
  task automatic hit_a();
    drive(3'd3, 3'd0, 4'b0000, 3'd3, 4'b0100, 1'b1, 1'b0);
  endtask

  task automatic hit_b();
    drive(3'd0, 3'd3, 4'b0000, 3'd3, 4'b0100, 1'b1, 1'b0);
  endtask

  task automatic bubble(input logic fl);
    drive(3'd0, 3'd0, 4'b0000, 3'd0, 4'b0000, 1'b0, fl);
  endtask

  task automatic release_reset();
    bubble(1'b0);
    reset = 1'b1;
  endtask

  task automatic do_reset();
    bubble(1'b0);
    reset = 1'b0;
    release_reset();
  endtask

  initial begin
    // Reset held with a hazard on the bus: all instances stay inactive.
    hit_a();
    for (int i = 0; i < 5; i++) push_exp(i, 1'b0, 2'b00, 16'd0, "reset_state");
    release_reset();

    // LOAD_LAT=1, hit via src1.
    hit_a();        push_exp(0, 1'b1, 2'b01, 16'd0, "ll1_detect");
    bubble(1'b0);   push_exp(0, 1'b0, 2'b00, 16'd1, "ll1_release");
    bubble(1'b0);   push_exp(0, 1'b0, 2'b00, 16'd1, "ll1_hold");
    do_reset();

    // LOAD_LAT=3, hit via src2.
    hit_b();        push_exp(1, 1'b1, 2'b10, 16'd0, "ll3_c0");
    bubble(1'b0);   push_exp(1, 1'b1, 2'b00, 16'd1, "ll3_c1");
    bubble(1'b0);   push_exp(1, 1'b1, 2'b00, 16'd2, "ll3_c2");
    bubble(1'b0);   push_exp(1, 1'b0, 2'b00, 16'd3, "ll3_end");
    do_reset();

    // Non-hazards.
    drive(3'd5, 3'd0, 4'b0000, 3'd5, 4'b0100, 1'b0, 1'b0);
    push_exp(0, 1'b0, 2'b00, 16'd0, "nh_invalid");
    drive(3'd5, 3'd0, 4'b0100, 3'd5, 4'b0100, 1'b1, 1'b0);
    push_exp(0, 1'b0, 2'b00, 16'd0, "nh_mask");
    drive(3'd5, 3'd0, 4'b0000, 3'd5, 4'b0000, 1'b1, 1'b0);
    push_exp(0, 1'b0, 2'b00, 16'd0, "nh_add");
    drive(3'd3, 3'd0, 4'b0000, 3'd3, 4'b0100, 1'b1, 1'b1);
    push_exp(0, 1'b0, 2'b00, 16'd0, "nh_flush");
    bubble(1'b0);
    push_exp(0, 1'b0, 2'b00, 16'd0, "nh_count");

    // Zero register: suppressed on instance 3, stalls on instance 0.
    drive(3'd0, 3'd7, 4'b0000, 3'd0, 4'b0100, 1'b1, 1'b0);
    push_exp(3, 1'b0, 2'b00, 16'd0, "zero_en");
    push_exp(0, 1'b1, 2'b01, 16'd0, "zero_dis");
    bubble(1'b0);
    push_exp(3, 1'b0, 2'b00, 16'd0, "zero_en_cnt");
    push_exp(0, 1'b0, 2'b00, 16'd1, "zero_dis_cnt");
    do_reset();

    // LOAD_LAT=4 aborted by flush in cycle 2; cycle 3 re-detects from IDLE.
    hit_a();        push_exp(2, 1'b1, 2'b01, 16'd0, "fl_c0");
    bubble(1'b0);   push_exp(2, 1'b1, 2'b00, 16'd1, "fl_c1");
    bubble(1'b1);   push_exp(2, 1'b0, 2'b00, 16'd2, "fl_c2");
    hit_a();        push_exp(2, 1'b1, 2'b01, 16'd2, "fl_c3_idle");
    bubble(1'b0);   push_exp(2, 1'b1, 2'b00, 16'd3, "fl_c4");
    do_reset();

    // Asynchronous reset in the middle of a LOAD_LAT=3 stall.
    hit_a();        push_exp(1, 1'b1, 2'b01, 16'd0, "rs_c0");
    bubble(1'b0);   push_exp(1, 1'b1, 2'b00, 16'd1, "rs_c1");
    hit_a();
    reset = 1'b0;
    push_exp(1, 1'b0, 2'b00, 16'd0, "rs_async");
    release_reset();
    hit_a();        push_exp(1, 1'b1, 2'b01, 16'd0, "rs_after");
    do_reset();

    // Saturation of a 4-bit counter over 20 stalled cycles.
    for (int i = 0; i < 20; i++) begin
      hit_a();
      push_exp(4, 1'b1, 2'b01, (i < 15) ? 16'(i) : 16'd15, "sat");
    end
    bubble(1'b0);   push_exp(4, 1'b0, 2'b00, 16'd15, "sat_hold");

    repeat (3) @(posedge clock);
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      $fatal(1, "scoreboard not drained");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
